// File: rtl/softmax_norm.sv
// softmax_norm: softmax row normalizer in front of an iterative divider.
//
// Buffers one row of unsigned exponent values and sums them. It then issues
// one divide per element, (x << FRAC) / sum, and streams the quotients out
// with valid/ready and last framing. The divider's variable latency stays
// hidden behind this block's request/collect handshake.
//
// Optional feature macro: SOFTMAX_NORM_ROUND_EN
//   defined   -> dividend = (x << FRAC) + (sum >> 1)  (round to nearest, ties up)
//   undefined -> dividend =  x << FRAC                (truncate)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   enable              global clock enable; low freezes all state and handshakes
//   in_valid/in_data/in_last/in_ready      row input stream
//   out_valid/out_data/out_last/out_ready  normalized output stream
//   div_in_valid/div_divisor/div_divident  request to the divider
//   div_quotient/div_out_valid             result from the divider
//   row_overflow        sticky flag: a row ran past MAX_LEN without in_last
module softmax_norm #(
  parameter int D_W     = 32,
  parameter int IN_W    = 16,
  parameter int FRAC    = 15,
  parameter int MAX_LEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_last,
  output logic            in_ready,
  output logic            out_valid,
  output logic [D_W-1:0]  out_data,
  output logic            out_last,
  input  logic            out_ready,
  output logic            div_in_valid,
  output logic [D_W-1:0]  div_divisor,
  output logic [D_W-1:0]  div_divident,
  input  logic [D_W-1:0]  div_quotient,
  input  logic            div_out_valid,
  output logic            row_overflow
);

  localparam int AW = $clog2(MAX_LEN);
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
  localparam logic [AW-1:0] PTR_MAX = AW'(MAX_LEN - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [D_W-1:0]  sum_q, sum_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   last_idx_q, last_idx_d;   // index of the row's final element
  logic            out_valid_q, out_valid_d;
  logic [D_W-1:0]  out_data_q, out_data_d;
  logic            out_last_q, out_last_d;
  logic            div_in_valid_q, div_in_valid_d;
  logic [D_W-1:0]  div_divisor_q, div_divisor_d;
  logic [D_W-1:0]  div_divident_q, div_divident_d;
  logic            row_overflow_q, row_overflow_d;

  logic [IN_W-1:0] row_mem_q [MAX_LEN];
  logic            mem_we;
  logic            in_fire;
  logic            out_fire;
  logic [D_W-1:0]  dividend;

  assign in_ready     = enable && (state_q == S_LOAD);
  assign in_fire      = in_valid && in_ready;
  assign out_fire     = out_valid_q && out_ready && enable;

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_last     = out_last_q;
  assign div_in_valid = div_in_valid_q;
  assign div_divisor  = div_divisor_q;
  assign div_divident = div_divident_q;
  assign row_overflow = row_overflow_q;

  // Dividend for the element at rd_ptr, optionally biased by sum/2 for rounding.
  always_comb begin
    dividend = {{(D_W-IN_W){1'b0}}, row_mem_q[rd_ptr_q]} << FRAC;
`ifdef SOFTMAX_NORM_ROUND_EN
    dividend = dividend + (sum_q >> 1);
`else
    dividend = dividend + {D_W{1'b0}};
`endif
  end

  // Next-state and next-output logic for the LOAD/ISSUE/WAIT/OUT sequencer.
  always_comb begin
    state_d        = state_q;
    sum_d          = sum_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    last_idx_d     = last_idx_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_last_d     = out_last_q;
    div_in_valid_d = 1'b0;          // request is a single-cycle pulse
    div_divisor_d  = div_divisor_q;
    div_divident_d = div_divident_q;
    row_overflow_d = row_overflow_q;
    mem_we         = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (in_fire) begin
          mem_we   = 1'b1;
          sum_d    = sum_q + {{(D_W-IN_W){1'b0}}, in_data};
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          if (in_last || (wr_ptr_q == PTR_MAX)) begin
            last_idx_d = wr_ptr_q;
            rd_ptr_d   = {AW{1'b0}};
            state_d    = S_ISSUE;
            // A full buffer without in_last closes the row early; the
            // following element simply begins the next row.
            if (!in_last) begin
              row_overflow_d = 1'b1;
            end else begin
              row_overflow_d = row_overflow_q;
            end
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end

      S_ISSUE: begin
        if (sum_q == {D_W{1'b0}}) begin
          // All-zero row: every output is 0, the divider is never bothered.
          out_data_d  = {D_W{1'b0}};
          out_valid_d = 1'b1;
          out_last_d  = (rd_ptr_q == last_idx_q);
          state_d     = S_OUT;
        end else begin
          div_in_valid_d = 1'b1;
          div_divisor_d  = sum_q;
          div_divident_d = dividend;
          state_d        = S_WAIT;
        end
      end

      S_WAIT: begin
        // The divider drops its quotient a cycle after out_valid, so it is
        // captured on the pulse itself.
        if (div_out_valid) begin
          out_data_d  = div_quotient;
          out_valid_d = 1'b1;
          out_last_d  = (rd_ptr_q == last_idx_q);
          state_d     = S_OUT;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_OUT: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            sum_d    = {D_W{1'b0}};
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            state_d  = S_LOAD;
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            state_d  = S_ISSUE;
          end
        end else begin
          state_d = S_OUT;
        end
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // Control and output registers; reset wins, otherwise advance only when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_LOAD;
      sum_q          <= {D_W{1'b0}};
      wr_ptr_q       <= {AW{1'b0}};
      rd_ptr_q       <= {AW{1'b0}};
      last_idx_q     <= {AW{1'b0}};
      out_valid_q    <= 1'b0;
      out_data_q     <= {D_W{1'b0}};
      out_last_q     <= 1'b0;
      div_in_valid_q <= 1'b0;
      div_divisor_q  <= {D_W{1'b0}};
      div_divident_q <= {D_W{1'b0}};
      row_overflow_q <= 1'b0;
    end else if (enable) begin
      state_q        <= state_d;
      sum_q          <= sum_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      last_idx_q     <= last_idx_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_last_q     <= out_last_d;
      div_in_valid_q <= div_in_valid_d;
      div_divisor_q  <= div_divisor_d;
      div_divident_q <= div_divident_d;
      row_overflow_q <= row_overflow_d;
    end
  end

  // Row buffer write port; contents need no reset since sum/pointers gate use.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      row_mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_softmax_norm.sv
// tb_softmax_norm: self-checking bench for softmax_norm.
// Contains a behavioural divider with random latency, a directed vector table,
// hand-written corner sequences (back-pressure hold, row overflow, reset
// mid-row) and random rows checked against a plain-arithmetic softmax model.
// Honours SOFTMAX_NORM_ROUND_EN for its expected values.
`timescale 1ns/1ps
module tb_softmax_norm;

  localparam int D_W = 32, IN_W = 16, FRAC = 15, MAX_LEN = 64;

`ifdef SOFTMAX_NORM_ROUND_EN
  localparam bit ROUND = 1'b1;
  localparam logic [D_W-1:0] HOLD1 = 32'd10923, BIG_A = 32'd32768, BIG_B = 32'd1;
`else
  localparam bit ROUND = 1'b0;
  localparam logic [D_W-1:0] HOLD1 = 32'd10922, BIG_A = 32'd32767, BIG_B = 32'd0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enable = 1'b1;
  logic            in_valid = 1'b0;
  logic [IN_W-1:0] in_data = '0;
  logic            in_last = 1'b0;
  logic            in_ready;
  logic            out_valid;
  logic [D_W-1:0]  out_data;
  logic            out_last;
  logic            out_ready = 1'b1;
  logic            div_in_valid;
  logic [D_W-1:0]  div_divisor, div_divident;
  logic [D_W-1:0]  div_quotient;
  logic            div_out_valid;
  logic            row_overflow;

  softmax_norm #(.D_W(D_W), .IN_W(IN_W), .FRAC(FRAC), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .div_in_valid(div_in_valid), .div_divisor(div_divisor), .div_divident(div_divident),
    .div_quotient(div_quotient), .div_out_valid(div_out_valid),
    .row_overflow(row_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural divider ----------------
  logic           busy;
  int             cnt;
  logic [D_W-1:0] dvd, dvs;
  int             pulses = 0;
  int             proto_err = 0;

  always @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0; cnt <= 0; div_out_valid <= 1'b0; div_quotient <= '0;
    end else if (enable) begin
      div_out_valid <= 1'b0;
      div_quotient  <= '0;
      if (div_in_valid) begin
        if (busy || div_divisor == 0) proto_err <= proto_err + 1;
        pulses <= pulses + 1;
        busy   <= 1'b1;
        cnt    <= int'($urandom_range(0, 4));
        dvd    <= div_divident;
        dvs    <= div_divisor;
      end else if (busy) begin
        if (cnt == 0) begin
          busy          <= 1'b0;
          div_out_valid <= 1'b1;
          div_quotient  <= dvd / dvs;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct { logic [D_W-1:0] d; logic l; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  function automatic logic [D_W-1:0] ref_q(input longint x, input longint s);
    if (s == 0) return '0;
    return D_W'(((x << FRAC) + (ROUND ? s / 2 : 0)) / s);
  endfunction

  int row_x [0:127];

  // Push expected outputs for row_x[0..n-1]; returns divides the row needs.
  function automatic int expect_row(input int n);
    longint s = 0;
    exp_t e;
    for (int k = 0; k < n; k++) s += row_x[k];
    for (int k = 0; k < n; k++) begin
      e.d = ref_q(row_x[k], s);
      e.l = (k == n - 1);
      exp_q.push_back(e);
    end
    return (s == 0) ? 0 : n;
  endfunction

  always @(negedge clk) begin
    if (!rst && enable && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_out", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", out_data, mon_e.d);
        check("out_last", out_last, mon_e.l);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit rnd_mode = 1'b0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_mode) begin
        out_ready = ($urandom_range(0, 3) != 0);
        enable    = ($urandom_range(0, 7) != 0);
      end
    end
  end

  task automatic push_elem(input logic [IN_W-1:0] d, input logic l);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) check("in_timeout", t, 0);
  endtask

  task automatic send_row(input int n);
    for (int k = 0; k < n; k++) push_elem(IN_W'(row_x[k]), (k == n - 1));
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int             n;
    int             x [4];
    logic [D_W-1:0] e [4];
    int             pulses;
  } vec_t;
  vec_t vecs [5];

  task automatic set_vec(input int i, input int n, input int x0, input int x1,
                         input int x2, input int x3, input logic [D_W-1:0] e0,
                         input logic [D_W-1:0] e1, input logic [D_W-1:0] e2,
                         input logic [D_W-1:0] e3, input int p);
    vecs[i].n = n;
    vecs[i].x[0] = x0; vecs[i].x[1] = x1; vecs[i].x[2] = x2; vecs[i].x[3] = x3;
    vecs[i].e[0] = e0; vecs[i].e[1] = e1; vecs[i].e[2] = e2; vecs[i].e[3] = e3;
    vecs[i].pulses = p;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, exp_pulses, t;
    exp_t e;

    set_vec(0, 4, 1, 1, 1, 1, 32'd8192, 32'd8192, 32'd8192, 32'd8192, 4);
    set_vec(1, 1, 5, 0, 0, 0, 32'd32768, 32'd0, 32'd0, 32'd0, 1);
    set_vec(2, 3, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 0);
    set_vec(3, 3, 7, 0, 9, 0, 32'd14336, 32'd0, 32'd18432, 32'd0, 3);
    set_vec(4, 2, 65535, 1, 0, 0, BIG_A, BIG_B, 32'd0, 32'd0, 2);

    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_div_in_valid", div_in_valid, 0);
    check("rst_div_divisor", div_divisor, 0);
    check("rst_div_divident", div_divident, 0);
    check("rst_row_overflow", row_overflow, 0);
    check("rst_in_ready", in_ready, 1);

    // table-driven rows
    for (int i = 0; i < 5; i++) begin
      p0 = pulses;
      for (int k = 0; k < vecs[i].n; k++) begin
        e.d = vecs[i].e[k];
        e.l = (k == vecs[i].n - 1);
        exp_q.push_back(e);
        row_x[k] = vecs[i].x[k];
      end
      send_row(vecs[i].n);
      wait_drain(2000);
      check("vec_pulses", pulses - p0, vecs[i].pulses);
    end

    // back-pressure: [1,2] with out_ready low for 10 cycles
    @(posedge clk); #1 out_ready = 1'b0;
    e.d = HOLD1; e.l = 1'b0; exp_q.push_back(e);
    e.d = 32'd21845; e.l = 1'b1; exp_q.push_back(e);
    row_x[0] = 1; row_x[1] = 2;
    send_row(2);
    t = 0;
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    for (int c = 0; c < 10; c++) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, HOLD1);
      check("hold_last", out_last, 0);
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain(2000);

    // overflow: 65 ones, in_last only on the 65th
    check("ovf_before", row_overflow, 0);
    for (int k = 0; k < 65; k++) row_x[k] = 1;
    for (int k = 0; k < 64; k++) begin
      e.d = 32'd512; e.l = (k == 63); exp_q.push_back(e);
    end
    e.d = 32'd32768; e.l = 1'b1; exp_q.push_back(e);
    send_row(65);
    wait_drain(5000);
    check("ovf_after", row_overflow, 1);

    // reset during WAIT of element 2 of [3,1,4,1]
    row_x[0] = 3; row_x[1] = 1; row_x[2] = 4; row_x[3] = 1;
    e.d = ref_q(3, 9); e.l = 1'b0; exp_q.push_back(e);
    p0 = pulses;
    send_row(4);
    t = 0;
    while (pulses < p0 + 2 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("mid_pulses", pulses - p0, 2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_in_ready", in_ready, 1);
    check("mid_out_valid", out_valid, 0);
    check("mid_div_in_valid", div_in_valid, 0);
    check("mid_pending", exp_q.size(), 0);
    rst = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      e.d = 32'd16384; e.l = (k == 1); exp_q.push_back(e);
      row_x[k] = 2;
    end
    send_row(2);
    wait_drain(2000);

    // random rows with random back-pressure and enable gaps
    rnd_mode = 1'b1;
    p0 = pulses;
    exp_pulses = 0;
    for (int r = 0; r < 30; r++) begin
      int n = int'($urandom_range(1, 20));
      int kind = int'($urandom_range(0, 5));
      for (int k = 0; k < n; k++) begin
        if (kind == 0)      row_x[k] = 0;
        else if (kind == 1) row_x[k] = int'($urandom_range(0, 3));
        else                row_x[k] = int'($urandom_range(0, 65535));
      end
      exp_pulses += expect_row(n);
      send_row(n);
    end
    wait_drain(40000);
    @(posedge clk); #1;
    rnd_mode = 1'b0; enable = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("rnd_pulses", pulses - p0, exp_pulses);
    check("div_protocol", proto_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
